// File: rtl/op_sequencer.sv
// ============================================================================
// op_sequencer : drives one shared 3-bit ripple adder to perform ADD/SUB/MUL/
//                INC; optional macro OPSEQ_ACCUM_EN turns op=11 into ACC.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module op_sequencer #(
  parameter int W  = 3,
  parameter int RW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  output logic          add_cin,
  input  logic [W-1:0]  add_s,
  input  logic          add_cout,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          neg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_NEG2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_INC = 2'b11;

  state_t        r_state, w_next;
  logic [1:0]    r_op;
  logic [W-1:0]  r_a, r_b, r_cnt;
  logic [RW-1:0] r_acc, r_result;
  logic          r_carry, r_neg;
  logic          w_multi;

  // Multi-pass ops loop LO/HI on r_acc; the loop test sits at the top of LO.
`ifdef OPSEQ_ACCUM_EN
  assign w_multi = (r_op == c_OP_MUL) || (r_op == c_OP_INC);
`else
  assign w_multi = (r_op == c_OP_MUL);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (op == c_OP_MUL && b == '0) ? S_DONE : S_LO;
      end
      S_LO: begin
        if (w_multi) begin
          add_a  = r_acc[W-1:0];
          add_b  = r_a;
          w_next = (r_cnt == '0) ? S_DONE : S_HI;
        end else if (r_op == c_OP_SUB) begin
          add_a   = r_a;
          add_b   = ~r_b;
          add_cin = 1'b1;
          w_next  = add_cout ? S_DONE : S_NEG2;
        end else begin
          add_a   = r_a;
          add_b   = r_b;
          add_cin = (r_op == c_OP_INC);
          w_next  = S_DONE;
        end
      end
      S_HI: begin
        add_a   = r_acc[RW-1:W];
        add_cin = r_carry;
        w_next  = S_LO;
      end
      S_NEG2: begin
        add_a   = r_b;
        add_b   = ~r_a;
        add_cin = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= c_OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= b;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_neg   <= 1'b0;
`ifdef OPSEQ_ACCUM_EN
            if (op == c_OP_INC) begin
              r_cnt <= W'(1);
              r_acc <= r_result;
            end
`endif
            if (op == c_OP_MUL && b == '0) r_result <= '0;
          end
        end
        S_LO: begin
          if (w_multi) begin
            if (r_cnt == '0) begin
              r_result <= r_acc;
            end else begin
              r_acc[W-1:0] <= add_s;
              r_carry      <= add_cout;
            end
          end else if (r_op == c_OP_SUB) begin
            if (add_cout) r_result <= {{(RW-W){1'b0}}, add_s};
          end else begin
            r_result <= {{(RW-W-1){1'b0}}, add_cout, add_s};
          end
        end
        S_HI: begin
          r_acc[RW-1:W] <= add_s;
          r_cnt         <= r_cnt - W'(1);
`ifdef OPSEQ_ACCUM_EN
          // Carry out of the high pass flags accumulator wrap.
          if (r_op == c_OP_INC) r_neg <= add_cout;
`endif
        end
        S_NEG2: begin
          r_result <= {{(RW-W){1'b0}}, add_s};
          r_neg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign neg    = r_neg;

endmodule

`default_nettype wire
